atm_session_controller: RTL and testbench

- Sequences one ATM card session around the shared balance store and the PIN authenticator.
- Admits a card, runs authentication with bounded retries, and accepts menu operations.
- Executes each operation as a read/modify/write transaction on the balance memory port using a req/ack handshake.
- Enforces an idle timeout and a lockout. Sits between the front-panel inputs and the balance database/authenticator.

---
 rtl/atm_session_controller.sv | 243 ++++++++++++++++++++++++
 tb/tb_atm_session_controller.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_session_controller.sv
// rtl/atm_session_controller.sv - ATM card session sequencer: auth, menu, balance read/modify/write
module atm_session_controller #(
  parameter int          MAX_ATTEMPTS   = 3,
  parameter int          TIMEOUT_CYCLES = 1000,
  parameter logic [15:0] MAX_WITHDRAW   = 16'd1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        card_in,
  input  logic [3:0]  acc_num,
  input  logic [15:0] pin,
  input  logic        pin_valid,
  output logic        auth_req,
  input  logic        auth_done,
  input  logic        auth_ok,
  input  logic [2:0]  operation,
  input  logic        op_valid,
  input  logic [15:0] amount,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        pin_upd,
  output logic [15:0] balance_out,
  output logic        done,
  output logic [1:0]  status,
  output logic        locked,
  output logic [2:0]  current_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_AUTH = 3'd1, S_MENU = 3'd2, S_RD = 3'd3,
    S_EXEC = 3'd4, S_WR = 3'd5, S_DONE = 3'd6, S_LOCKED = 3'd7
  } state_t;

  localparam int AW = $clog2(MAX_ATTEMPTS + 1);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AW-1:0] ATT_MAX  = AW'(MAX_ATTEMPTS);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_OK = 2'd0, ST_INSUFF = 2'd1, ST_INVALID = 2'd2, ST_OVERFLOW = 2'd3;

  state_t          state, state_next;
  logic [AW-1:0]   attempts;
  logic [CW-1:0]   idle_cnt;
  logic [2:0]      op_q;
  logic [15:0]     amt_q, bal_q;
  logic            end_q;

  logic            auth_req_d, pin_upd_d, done_d, mem_req_d, mem_we_d;
  logic [3:0]      mem_addr_d;
  logic [15:0]     mem_wdata_d, balance_d;
  logic [1:0]      status_d;

  logic            exec_write;
  logic [1:0]      exec_status;
  logic [15:0]     exec_wdata;
  logic [16:0]     sum17;
  logic            ack_seen, leaving, in_txn;
  state_t          ret_state;

  // The PIN value is consumed by the authenticator directly; nothing here reads it.
  logic unused_pin;
  assign unused_pin = ^pin;

  assign current_state = state;
  assign ack_seen      = mem_req & mem_ack;
  assign in_txn        = (state == S_RD) || (state == S_EXEC) || (state == S_WR) || (state == S_DONE);
  assign leaving       = end_q | ~card_in;
  assign ret_state     = leaving ? S_IDLE : S_MENU;

  // Arithmetic and limit checks for the latched operation against the fetched balance
  always_comb begin
    sum17       = {1'b0, bal_q} + {1'b0, amt_q};
    exec_write  = 1'b0;
    exec_status = ST_OK;
    exec_wdata  = bal_q;
    case (op_q)
      3'd2: begin
        if (amt_q == 16'd0 || amt_q > MAX_WITHDRAW) exec_status = ST_INVALID;
        else if (amt_q > bal_q)                     exec_status = ST_INSUFF;
        else begin
          exec_write = 1'b1;
          exec_wdata = bal_q - amt_q;
        end
      end
      3'd3: begin
        if (amt_q == 16'd0)  exec_status = ST_INVALID;
        else if (sum17[16])  exec_status = ST_OVERFLOW;
        else begin
          exec_write = 1'b1;
          exec_wdata = sum17[15:0];
        end
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state selection
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (card_in && pin_valid && acc_num <= 4'd9) state_next = S_AUTH;
      S_AUTH: begin
        if (!card_in)      state_next = S_IDLE;
        else if (auth_done) begin
          if (auth_ok)                             state_next = S_MENU;
          else if (attempts + AW'(1) >= ATT_MAX)   state_next = S_LOCKED;
          else                                     state_next = S_IDLE;
        end
      end
      S_MENU: begin
        if (!card_in) state_next = S_IDLE;
        else if (op_valid) begin
          case (operation)
            3'd1, 3'd2, 3'd3: state_next = S_RD;
            3'd5:             state_next = S_IDLE;
            default:          state_next = S_MENU;
          endcase
        end
        else if (idle_cnt == CNT_LAST) state_next = S_IDLE;
      end
      S_RD:     if (ack_seen) state_next = S_EXEC;
      S_EXEC:   state_next = exec_write ? S_WR : ret_state;
      S_WR:     if (ack_seen) state_next = S_DONE;
      S_DONE:   state_next = ret_state;
      S_LOCKED: if (!card_in) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; strobes default low, the rest hold
  always_comb begin
    auth_req_d  = 1'b0;
    pin_upd_d   = 1'b0;
    done_d      = 1'b0;
    status_d    = status;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    balance_d   = balance_out;
    case (state)
      S_IDLE: begin
        if (card_in && pin_valid) begin
          if (acc_num > 4'd9) begin
            done_d   = 1'b1;
            status_d = ST_INVALID;
          end else begin
            auth_req_d = 1'b1;
            mem_addr_d = acc_num;
          end
        end
      end
      S_MENU: begin
        if (card_in && op_valid) begin
          case (operation)
            3'd1, 3'd2, 3'd3: begin
              mem_req_d = 1'b1;
              mem_we_d  = 1'b0;
            end
            3'd4: begin
              pin_upd_d = 1'b1;
              done_d    = 1'b1;
              status_d  = ST_OK;
            end
            3'd5: ;
            default: begin
              done_d   = 1'b1;
              status_d = ST_INVALID;
            end
          endcase
        end
      end
      S_RD: if (ack_seen) mem_req_d = 1'b0;
      S_EXEC: begin
        if (exec_write) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_wdata_d = exec_wdata;
        end else begin
          done_d   = 1'b1;
          status_d = exec_status;
          if (op_q == 3'd1) balance_d = bal_q;
        end
      end
      S_WR: begin
        if (ack_seen) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          balance_d = mem_wdata;
        end
      end
      S_DONE: begin
        done_d   = 1'b1;
        status_d = ST_OK;
      end
      default: ;
    endcase
  end

  // Output registers plus session bookkeeping (attempts, idle timer, latched operation)
  always_ff @(posedge clk) begin
    if (rst) begin
      auth_req <= 1'b0; pin_upd <= 1'b0; done <= 1'b0; status <= ST_OK;
      mem_req <= 1'b0; mem_we <= 1'b0; mem_addr <= 4'd0; mem_wdata <= 16'd0;
      balance_out <= 16'd0; locked <= 1'b0; attempts <= '0; idle_cnt <= '0;
      op_q <= 3'd0; amt_q <= 16'd0; bal_q <= 16'd0; end_q <= 1'b0;
    end else begin
      auth_req    <= auth_req_d;
      pin_upd     <= pin_upd_d;
      done        <= done_d;
      status      <= status_d;
      mem_req     <= mem_req_d;
      mem_we      <= mem_we_d;
      mem_addr    <= mem_addr_d;
      mem_wdata   <= mem_wdata_d;
      balance_out <= balance_d;
      locked      <= (state_next == S_LOCKED);
      if (state == S_AUTH && card_in && auth_done)
        attempts <= auth_ok ? '0 : attempts + AW'(1);
      else if (state == S_LOCKED && !card_in)
        attempts <= '0;
      idle_cnt <= (state == S_MENU && !op_valid) ? idle_cnt + CW'(1) : '0;
      if (state == S_MENU && card_in && op_valid) begin
        op_q  <= operation;
        amt_q <= amount;
      end
      if (state == S_RD && ack_seen) bal_q <= mem_rdata;
      // Card pulled mid-transaction: finish the transaction, then end the session
      end_q <= in_txn && leaving;
    end
  end

endmodule

// File: tb/tb_atm_session_controller.sv
// tb/tb_atm_session_controller.sv - self-checking bench for atm_session_controller
module tb_atm_session_controller;
  logic        clk = 1'b0;
  logic        rst, card_in, pin_valid, auth_done, auth_ok, op_valid, mem_ack;
  logic [3:0]  acc_num;
  logic [15:0] pin, amount, mem_rdata;
  logic [2:0]  operation;
  logic        auth_req, mem_req, mem_we, pin_upd, done, locked;
  logic [3:0]  mem_addr;
  logic [15:0] mem_wdata, balance_out;
  logic [1:0]  status;
  logic [2:0]  current_state;

  localparam int TMO = 1000;

  atm_session_controller dut (
    .clk(clk), .rst(rst), .card_in(card_in), .acc_num(acc_num), .pin(pin),
    .pin_valid(pin_valid), .auth_req(auth_req), .auth_done(auth_done), .auth_ok(auth_ok),
    .operation(operation), .op_valid(op_valid), .amount(amount), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .pin_upd(pin_upd), .balance_out(balance_out), .done(done),
    .status(status), .locked(locked), .current_state(current_state)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  logic [15:0] store [16];
  int model_bal [16];
  int done_cnt = 0, pin_cnt = 0, auth_cnt = 0, req_cnt = 0, wr_cnt = 0, hs_err = 0;
  int ack_delay = 1, age = 0, exp_bout = 0;
  bit in_req = 0;
  logic [1:0]  last_status = 2'd0;
  logic [15:0] last_wdata = 16'd0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Spec rules for one balance operation: resulting status, new balance, whether a write happens
  function automatic void predict(input int op, input int amt, input int bal,
                                  output int st, output int nb, output bit wr);
    st = 0; nb = bal; wr = 0;
    if (op == 2) begin
      if (amt == 0 || amt > 1000) st = 2;
      else if (amt > bal)         st = 1;
      else begin nb = bal - amt; wr = 1; end
    end else if (op == 3) begin
      if (amt == 0)                st = 2;
      else if (bal + amt > 65535)  st = 3;
      else begin nb = bal + amt; wr = 1; end
    end
  endfunction

  // Balance store responder: ack after ack_delay cycles, one-cycle ack
  initial begin
    mem_ack = 1'b0; mem_rdata = 16'd0;
    forever begin
      @(posedge clk); #1;
      if (mem_ack) begin
        mem_ack = 1'b0;
        if (mem_req) hs_err++;
      end else if (mem_req) begin
        if (!in_req) begin
          in_req = 1; age = 0; req_cnt++;
          if (mem_we) wr_cnt++;
        end else age++;
        if (age >= ack_delay) begin
          if (mem_we) begin store[mem_addr] = mem_wdata; last_wdata = mem_wdata; end
          mem_rdata = store[mem_addr];
          mem_ack   = 1'b1;
          in_req    = 0;
        end
      end else in_req = 0;
    end
  end

  // Strobe monitor
  initial forever begin
    @(negedge clk);
    if (done) begin done_cnt++; last_status = status; end
    if (pin_upd)  pin_cnt++;
    if (auth_req) auth_cnt++;
  end

  task automatic login(input logic [3:0] acc, input logic ok);
    int a0;
    a0 = auth_cnt;
    card_in = 1; acc_num = acc; pin = 16'($urandom); pin_valid = 1; tick(); pin_valid = 0;
    check("auth_state", current_state, 1);
    auth_done = 1; auth_ok = ok; tick(); auth_done = 0; auth_ok = 0;
    check("auth_req_pulse", auth_cnt - a0, 1);
  endtask

  task automatic issue(input int op, input int amt);
    operation = op[2:0]; amount = amt[15:0]; op_valid = 1; tick(); op_valid = 0;
  endtask

  task automatic wait_done(input int d0, input string tag);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 300) begin tick(); n++; end
    check({tag, "_done"}, done_cnt - d0, 1);
  endtask

  task automatic run_op(input logic [3:0] acc, input int op, input int amt, input string tag);
    int st, nb, r0, w0, d0;
    bit wr;
    predict(op, amt, model_bal[acc], st, nb, wr);
    r0 = req_cnt; w0 = wr_cnt; d0 = done_cnt;
    issue(op, amt);
    wait_done(d0, tag);
    check({tag, "_status"}, last_status, st);
    check({tag, "_reqs"}, req_cnt - r0, wr ? 2 : 1);
    check({tag, "_writes"}, wr_cnt - w0, wr ? 1 : 0);
    if (op == 1 || wr) exp_bout = nb;
    if (wr) model_bal[acc] = nb;
    check({tag, "_balance_out"}, balance_out, exp_bout);
    check({tag, "_store"}, store[acc], model_bal[acc]);
    check({tag, "_state"}, current_state, 2);
  endtask

  task automatic menu_only(input int op, input int st, input int pins, input string tag);
    int r0, p0, d0;
    r0 = req_cnt; p0 = pin_cnt; d0 = done_cnt;
    issue(op, 0);
    wait_done(d0, tag);
    check({tag, "_status"}, last_status, st);
    check({tag, "_reqs"}, req_cnt - r0, 0);
    check({tag, "_pin_upd"}, pin_cnt - p0, pins);
    check({tag, "_state"}, current_state, 2);
  endtask

  initial begin
    int d0, a0, n, acc, op, amt;
    rst = 1; card_in = 0; acc_num = 0; pin = 0; pin_valid = 0; auth_done = 0; auth_ok = 0;
    operation = 0; op_valid = 0; amount = 0;
    for (int i = 0; i < 16; i++) begin
      store[i] = 16'($urandom_range(0, 60000)); model_bal[i] = int'(store[i]);
    end
    repeat (3) tick();
    check("rst_state", current_state, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_locked", locked, 0);
    check("rst_balance_out", balance_out, 0);
    check("rst_done", done, 0);
    rst = 0; tick();

    // Directed balance / withdraw / deposit sequence on account 2
    store[2] = 16'd500; model_bal[2] = 500;
    login(4'd2, 1'b1);
    check("login_menu", current_state, 2);
    run_op(4'd2, 1, 0, "balance500");
    run_op(4'd2, 2, 200, "withdraw200");
    check("withdraw200_wdata", last_wdata, 300);
    run_op(4'd2, 2, 400, "withdraw400");
    store[2] = 16'd65500; model_bal[2] = 65500;
    run_op(4'd2, 3, 100, "deposit_ovf");
    run_op(4'd2, 3, 0, "deposit0");
    run_op(4'd2, 2, 1001, "withdraw1001");
    run_op(4'd2, 2, 1000, "withdraw1000");
    menu_only(4, 0, 1, "change_pin");
    menu_only(6, 2, 0, "bad_op");
    issue(5, 0);
    check("exit_idle", current_state, 0);

    // Randomized sessions against the reference model
    for (int s = 0; s < 4; s++) begin
      acc = $urandom_range(0, 9);
      login(acc[3:0], 1'b1);
      check("rnd_login", current_state, 2);
      for (int k = 0; k < 8; k++) begin
        ack_delay = $urandom_range(1, 4);
        op = $urandom_range(1, 3);
        if (op == 2) amt = $urandom_range(0, 1200);
        else if (op == 3) amt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 2000);
        else amt = 0;
        run_op(acc[3:0], op, amt, "rnd_op");
      end
      issue(5, 0);
      check("rnd_exit", current_state, 0);
    end
    ack_delay = 1;

    // Out-of-range account
    a0 = auth_cnt; d0 = done_cnt;
    card_in = 1; acc_num = 4'd12; pin_valid = 1; tick(); pin_valid = 0; tick();
    check("acc12_done", done_cnt - d0, 1);
    check("acc12_status", last_status, 2);
    check("acc12_state", current_state, 0);
    check("acc12_no_auth", auth_cnt - a0, 0);

    // Lockout
    login(4'd1, 1'b0); check("fail1_idle", current_state, 0);
    login(4'd1, 1'b0); check("fail2_idle", current_state, 0);
    login(4'd1, 1'b0);
    check("fail3_locked_state", current_state, 7);
    check("fail3_locked", locked, 1);
    a0 = auth_cnt;
    pin_valid = 1; tick(); pin_valid = 0; tick();
    check("locked_pin_ignored", current_state, 7);
    check("locked_no_auth", auth_cnt - a0, 0);
    card_in = 0; tick();
    check("unlock_idle", current_state, 0);
    check("unlock_locked", locked, 0);
    login(4'd1, 1'b0);
    login(4'd1, 1'b0);
    check("attempts_cleared", current_state, 0);
    login(4'd1, 1'b1);
    check("after_clear_menu", current_state, 2);
    issue(5, 0);

    // Card pulled while write ack is pending
    store[3] = 16'd1000; model_bal[3] = 1000;
    login(4'd3, 1'b1);
    ack_delay = 5;
    d0 = done_cnt;
    issue(2, 100);
    n = 0;
    while (!(mem_req && mem_we) && n < 50) begin tick(); n++; end
    check("pull_write_seen", mem_req && mem_we, 1);
    card_in = 0;
    wait_done(d0, "pull");
    check("pull_status", last_status, 0);
    check("pull_store", store[3], 900);
    check("pull_balance_out", balance_out, 900);
    check("pull_state_idle", current_state, 0);
    model_bal[3] = 900; exp_bout = 900; ack_delay = 1;

    // Idle timeout: exactly TMO cycles in MENU
    login(4'd5, 1'b1);
    repeat (TMO - 1) tick();
    check("tmo_still_menu", current_state, 2);
    tick();
    check("tmo_idle", current_state, 0);
    login(4'd5, 1'b1);
    repeat (TMO - 1) tick();
    a0 = pin_cnt;
    issue(4, 0);
    check("tmo_restart_menu", current_state, 2);
    repeat (TMO - 1) tick();
    check("tmo_restart_still_menu", current_state, 2);
    check("tmo_restart_pin_upd", pin_cnt - a0, 1);
    tick();
    check("tmo_restart_idle", current_state, 0);

    // Reset in the middle of a read
    login(4'd4, 1'b1);
    ack_delay = 6;
    issue(1, 0);
    tick();
    check("rst_mid_req_up", mem_req, 1);
    rst = 1; tick();
    check("rst_mid_req_drop", mem_req, 0);
    check("rst_mid_state", current_state, 0);
    check("rst_mid_balance_out", balance_out, 0);
    rst = 0; tick(); tick();
    check("handshake_rules", hs_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
